// File: rtl/cc_pkg.sv
// Shared cache-controller definitions: bus widths, beat geometry and the
// serializer state encoding.
package cc_pkg;

   localparam int CC_DATA_W = 64;
   localparam int CC_LINE_W = 512;
   localparam int CC_BEATS  = 8;
   localparam int CC_OFF_W  = 3;
   localparam int CC_RESP_W = CC_LINE_W + CC_OFF_W;

   typedef enum logic {
      S_IDLE,
      S_SEND
   } cc_state_e;

   // Critical-word-first position; the 3-bit sum wraps naturally around the line.
   function automatic logic [CC_OFF_W-1:0] cc_beat_ptr(
      input logic [CC_OFF_W-1:0] offset,
      input logic [CC_OFF_W-1:0] cnt
   );
      return offset + cnt;
   endfunction

endpackage

// File: rtl/cc_line_serializer.sv
// Read-response serializer: pops a 512-bit line plus start offset from a
// show-ahead FIFO and streams it as eight wrap-ordered beats on AXI R.
module cc_line_serializer
   import cc_pkg::*;
#(
   parameter int DATA_W = CC_DATA_W,
   parameter int BEATS  = CC_BEATS,
   parameter int OFF_W  = CC_OFF_W
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          resp_fifo_empty_i,
   input  logic [DATA_W*BEATS+OFF_W-1:0] resp_fifo_rdata_i,
   output logic                          resp_fifo_rden_o,
   output logic [DATA_W-1:0]             rdata_o,
   output logic                          rlast_o,
   output logic                          rvalid_o,
   input  logic                          rready_i
);

   localparam int LINE_W = DATA_W * BEATS;
   localparam logic [OFF_W-1:0] LAST_CNT = OFF_W'(BEATS - 1);

   cc_state_e          state_q, state_d;
   logic [LINE_W-1:0]  line_q, line_d;
   logic [OFF_W-1:0]   offset_q, offset_d;
   logic [OFF_W-1:0]   cnt_q, cnt_d;
   logic               pop;
   logic [OFF_W-1:0]   ptr;
   logic [DATA_W-1:0]  beat_words [BEATS];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         line_q   <= '0;
         offset_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         line_q   <= line_d;
         offset_q <= offset_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state logic; the pop strobe rides along since it shares the load decision.
   always_comb begin
      state_d  = state_q;
      line_d   = line_q;
      offset_d = offset_q;
      cnt_d    = cnt_q;
      pop      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!resp_fifo_empty_i) begin
               pop     = 1'b1;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (rready_i) begin
               if (cnt_q != LAST_CNT) begin
                  cnt_d = cnt_q + 1'b1;
               end else if (!resp_fifo_empty_i) begin
                  pop = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (pop) begin
         line_d   = resp_fifo_rdata_i[LINE_W-1:0];
         offset_d = resp_fifo_rdata_i[LINE_W+OFF_W-1:LINE_W];
         cnt_d    = '0;
      end
   end

   assign resp_fifo_rden_o = pop & rst_n;

   for (genvar gi = 0; gi < BEATS; gi++) begin : g_words
      assign beat_words[gi] = line_q[gi*DATA_W +: DATA_W];
   end

   assign ptr = cc_beat_ptr(offset_q, cnt_q);

   // Output logic: registered state only, so rready_i never reaches the R payload.
   always_comb begin
      rvalid_o = (state_q == S_SEND);
      rlast_o  = (state_q == S_SEND) && (cnt_q == LAST_CNT);
      rdata_o  = beat_words[ptr];
   end

endmodule

// File: tb/tb_cc_line_serializer.sv
// Directed bench for cc_line_serializer with a show-ahead FIFO model.
module tb_cc_line_serializer;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         resp_fifo_empty_i;
   logic [514:0] resp_fifo_rdata_i;
   logic         resp_fifo_rden_o;
   logic [63:0]  rdata_o;
   logic         rlast_o;
   logic         rvalid_o;
   logic         rready_i;

   logic [514:0] fifo [$];
   int           pop_cnt = 0;
   int           checks  = 0;
   int           errors  = 0;

   always #5 clk = ~clk;

   cc_line_serializer dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .resp_fifo_empty_i (resp_fifo_empty_i),
      .resp_fifo_rdata_i (resp_fifo_rdata_i),
      .resp_fifo_rden_o  (resp_fifo_rden_o),
      .rdata_o           (rdata_o),
      .rlast_o           (rlast_o),
      .rvalid_o          (rvalid_o),
      .rready_i          (rready_i)
   );

   always @(posedge clk) begin
      if (resp_fifo_rden_o && fifo.size() > 0) begin
         void'(fifo.pop_front());
         pop_cnt++;
      end
   end

   function automatic logic [511:0] mk_line(input logic [63:0] base);
      logic [511:0] l;
      for (int i = 0; i < 8; i++) l[i*64 +: 64] = base + 64'(i);
      return l;
   endfunction

   task automatic push(input logic [63:0] base, input logic [2:0] off);
      fifo.push_back({off, mk_line(base)});
   endtask

   // Drive one cycle's inputs in the low phase, then sample just after.
   task automatic cyc(input logic rr, input logic rst);
      @(negedge clk);
      rst_n             = rst;
      rready_i          = rr;
      resp_fifo_empty_i = (fifo.size() == 0);
      resp_fifo_rdata_i = (fifo.size() == 0) ? '0 : fifo[0];
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic l,
                          input logic [63:0] d, input logic rd);
      chk({tag, ".rvalid"}, 64'(rvalid_o), 64'(v));
      chk({tag, ".rlast"},  64'(rlast_o),  64'(l));
      if (v) chk({tag, ".rdata"}, rdata_o, d);
      chk({tag, ".rden"},   64'(resp_fifo_rden_o), 64'(rd));
      $display("step %s rvalid=%0b rlast=%0b rdata=%h rden=%0b",
               tag, rvalid_o, rlast_o, rdata_o, resp_fifo_rden_o);
   endtask

   // Beat k of a line: expected word index is (off + k) mod 8.
   task automatic beat(input string tag, input logic [63:0] base, input logic [2:0] off,
                       input int k, input logic rr, input logic exp_rden);
      logic [2:0] w;
      w = off + 3'(k);
      cyc(rr, 1'b1);
      chk_all($sformatf("%s.b%0d", tag, k), 1'b1, (k == 7), base + 64'(w), exp_rden);
   endtask

   localparam logic [63:0] A = 64'hA000_0000_0000_0000;
   localparam logic [63:0] B = 64'hB000_0000_0000_0000;
   localparam logic [63:0] C = 64'hC000_0000_0000_0000;
   localparam logic [63:0] D = 64'hD000_0000_0000_0000;
   localparam logic [63:0] E = 64'hE000_0000_0000_0000;
   localparam logic [63:0] F = 64'hF000_0000_0000_0000;
   localparam logic [63:0] G = 64'h1234_0000_0000_0000;

   initial begin
      rst_n = 1'b0; rready_i = 1'b1; resp_fifo_empty_i = 1'b1; resp_fifo_rdata_i = '0;

      // Reset with a line already waiting: no pop, all outputs zero.
      push(A, 3'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0);
         chk_all($sformatf("rst%0d", i), 1'b0, 1'b0, 64'd0, 1'b0);
         chk("rst.rdata", rdata_o, 64'd0);
      end

      // Offset 0: rden at T, beats W0..W7 at T+1..T+8.
      cyc(1'b1, 1'b1);
      chk_all("A.pop", 1'b0, 1'b0, 64'd0, 1'b1);
      for (int k = 0; k < 8; k++) beat("A", A, 3'd0, k, 1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      chk_all("A.done", 1'b0, 1'b0, 64'd0, 1'b0);

      // Offset 5: W5,W6,W7,W0..W4 with rlast on W4.
      push(B, 3'd5);
      cyc(1'b1, 1'b1);
      chk_all("B.pop", 1'b0, 1'b0, 64'd0, 1'b1);
      for (int k = 0; k < 8; k++) beat("B", B, 3'd5, k, 1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      chk_all("B.done", 1'b0, 1'b0, 64'd0, 1'b0);

      // Two queued lines: second pop on the first rlast handshake, no bubble.
      push(C, 3'd2);
      push(D, 3'd7);
      cyc(1'b1, 1'b1);
      chk_all("C.pop", 1'b0, 1'b0, 64'd0, 1'b1);
      for (int k = 0; k < 8; k++) beat("C", C, 3'd2, k, 1'b1, (k == 7));
      for (int k = 0; k < 8; k++) beat("D", D, 3'd7, k, 1'b1, 1'b0);
      cyc(1'b1, 1'b1);
      chk_all("D.done", 1'b0, 1'b0, 64'd0, 1'b0);
      chk("pops.CD", 64'(pop_cnt), 64'd4);

      // Stalls: rready 1,0,0,1 hold beat 1; a stalled last beat must not pop.
      push(E, 3'd3);
      cyc(1'b1, 1'b1);
      chk_all("E.pop", 1'b0, 1'b0, 64'd0, 1'b1);
      beat("E", E, 3'd3, 0, 1'b1, 1'b0);
      beat("E.s0", E, 3'd3, 1, 1'b0, 1'b0);
      beat("E.s1", E, 3'd3, 1, 1'b0, 1'b0);
      beat("E", E, 3'd3, 1, 1'b1, 1'b0);
      for (int k = 2; k < 7; k++) beat("E", E, 3'd3, k, 1'b1, 1'b0);
      push(F, 3'd0);
      beat("E.s2", E, 3'd3, 7, 1'b0, 1'b0);
      beat("E", E, 3'd3, 7, 1'b1, 1'b1);

      // Reset after three beats of F: no pop during reset, IDLE next cycle.
      for (int k = 0; k < 3; k++) beat("F", F, 3'd0, k, 1'b1, 1'b0);
      push(G, 3'd6);
      cyc(1'b1, 1'b0);
      chk("F.rst.rden", 64'(resp_fifo_rden_o), 64'd0);
      cyc(1'b1, 1'b0);
      chk_all("F.rst", 1'b0, 1'b0, 64'd0, 1'b0);
      chk("F.rst.rdata", rdata_o, 64'd0);
      cyc(1'b1, 1'b1);
      chk_all("G.pop", 1'b0, 1'b0, 64'd0, 1'b1);
      for (int k = 0; k < 8; k++) beat("G", G, 3'd6, k, 1'b1, 1'b0);

      // FIFO empty throughout: stays idle.
      for (int i = 0; i < 12; i++) begin
         cyc(1'b1, 1'b1);
         chk_all($sformatf("empty%0d", i), 1'b0, 1'b0, 64'd0, 1'b0);
      end
      chk("pops.total", 64'(pop_cnt), 64'd7);
      chk("fifo.left", 64'(fifo.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
